// File: rtl/tick_stopwatch_if.sv
// tick_stopwatch_if: tick/button inputs and time/status outputs
// of the 10 ms stopwatch consumer.
interface tick_stopwatch_if;
  logic       tick_10msec;
  logic       btn_run;
  logic       btn_clear;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic       running;
  logic       rollover;
  logic       tick_lost;

  modport master (
    output tick_10msec,
    output btn_run,
    output btn_clear,
    input  msec,
    input  sec,
    input  min,
    input  running,
    input  rollover,
    input  tick_lost
  );

  modport slave (
    input  tick_10msec,
    input  btn_run,
    input  btn_clear,
    output msec,
    output sec,
    output min,
    output running,
    output rollover,
    output tick_lost
  );
endinterface

// File: rtl/tick_stopwatch.sv
// tick_stopwatch: edge-qualified 10 ms tick into a run/stop/clear
// mm:ss.cc stopwatch, with a watchdog on the tick stream.
module tick_stopwatch #(
  parameter int unsigned TIMEOUT_CYC = 1_100_000
) (
  input  logic             clk,
  input  logic             rst,
  tick_stopwatch_if.slave  bus
);

  localparam int unsigned GW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_CYC);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e        state_q;
  state_e        state_d;

  logic          tick_q;
  logic          tick_rise;

  logic [6:0]    msec_q;
  logic [5:0]    sec_q;
  logic [5:0]    min_q;
  logic          roll_q;

  logic [GW-1:0] gap_q;
  logic [GW-1:0] gap_d;
  logic          lost_q;

  logic          inc_en;
  logic          clr_en;
  logic          ms_wrap;
  logic          s_wrap;
  logic          m_wrap;

  // tick_q resets high so a tick already high at release is ignored
  assign tick_rise = bus.tick_10msec & ~tick_q;

  // Previous tick level for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= 1'b1;
    end else begin
      tick_q <= bus.tick_10msec;
    end
  end

  // Run/stop state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and count/clear enables from the current state
  always_comb begin
    state_d = state_q;
    inc_en  = 1'b0;
    clr_en  = 1'b0;
    unique case (state_q)
      ST_STOP: begin
        clr_en = bus.btn_clear;
        if (bus.btn_run && !bus.btn_clear) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        inc_en = tick_rise;
        if (bus.btn_run) begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_STOP;
      end
    endcase
  end

  // Carry chain: each digit group wraps only when all lower ones do
  always_comb begin
    ms_wrap = inc_en & (msec_q == 7'd99);
    s_wrap  = ms_wrap & (sec_q == 6'd59);
    m_wrap  = s_wrap & (min_q == 6'd59);
  end

  // Time registers: clear in STOP, increment in RUN on a tick edge
  always_ff @(posedge clk) begin
    if (rst) begin
      msec_q <= '0;
      sec_q  <= '0;
      min_q  <= '0;
    end else if (clr_en) begin
      msec_q <= '0;
      sec_q  <= '0;
      min_q  <= '0;
    end else if (inc_en) begin
      msec_q <= ms_wrap ? 7'd0 : msec_q + 7'd1;
      if (ms_wrap) begin
        sec_q <= s_wrap ? 6'd0 : sec_q + 6'd1;
      end
      if (s_wrap) begin
        min_q <= m_wrap ? 6'd0 : min_q + 6'd1;
      end
    end
  end

  // One-cycle pulse after the 59:59.99 -> 00:00.00 wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      roll_q <= 1'b0;
    end else begin
      roll_q <= m_wrap;
    end
  end

  // Gap counter: restart on each tick edge, saturate at the limit
  always_comb begin
    gap_d = gap_q;
    if (tick_rise) begin
      gap_d = '0;
    end else if (gap_q != GAP_MAX) begin
      gap_d = gap_q + GW'(1);
    end
  end

  // Watchdog state; tick_lost follows the saturated gap count
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q  <= '0;
      lost_q <= 1'b0;
    end else begin
      gap_q  <= gap_d;
      lost_q <= (gap_d == GAP_MAX);
    end
  end

  assign bus.msec      = msec_q;
  assign bus.sec       = sec_q;
  assign bus.min       = min_q;
  assign bus.running   = (state_q == ST_RUN);
  assign bus.rollover  = roll_q;
  assign bus.tick_lost = lost_q;

endmodule

// File: tb/tb_tick_stopwatch.sv
// tb_tick_stopwatch: directed stimulus against a centisecond-total
// reference model, checked every cycle plus literal checkpoints.
module tb_tick_stopwatch;

  localparam int T = 50;
  localparam int WRAP = 360000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tick_stopwatch_if bus ();

  tick_stopwatch #(
    .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int errs = 0;
  int chks = 0;

  task automatic chk(input string nm, input int got, input int exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d want=%0d", nm, got, exp);
    end
  endtask

  // Reference: elapsed time as one centisecond total
  int m_cs = 0;
  int m_run = 0;
  int m_roll = 0;
  int m_gap = 0;
  int m_prev = 1;
  int m_rise = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cs = 0;
      m_run = 0;
      m_roll = 0;
      m_gap = 0;
      m_prev = 1;
    end else begin
      m_rise = (bus.tick_10msec && m_prev == 0) ? 1 : 0;
      m_prev = bus.tick_10msec ? 1 : 0;
      m_roll = 0;
      if (m_run == 1 && m_rise == 1) begin
        m_cs = m_cs + 1;
        if (m_cs == WRAP) begin
          m_cs = 0;
          m_roll = 1;
        end
      end
      if (m_run == 0 && bus.btn_clear) m_cs = 0;
      else if (bus.btn_run) m_run = 1 - m_run;
      if (m_rise == 1) m_gap = 0;
      else if (m_gap < T) m_gap = m_gap + 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_msec", int'(bus.msec), m_cs % 100);
      chk("cyc_sec", int'(bus.sec), (m_cs / 100) % 60);
      chk("cyc_min", int'(bus.min), m_cs / 6000);
      chk("cyc_running", int'(bus.running), m_run);
      chk("cyc_rollover", int'(bus.rollover), m_roll);
      chk("cyc_lost", int'(bus.tick_lost), (m_gap == T) ? 1 : 0);
    end
  end

  task automatic pulse(input int h, input int l);
    bus.tick_10msec = 1'b1;
    repeat (h) @(negedge clk);
    bus.tick_10msec = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic press(input bit r, input bit c);
    bus.btn_run = r;
    bus.btn_clear = c;
    @(negedge clk);
    bus.btn_run = 1'b0;
    bus.btn_clear = 1'b0;
  endtask

  task automatic chk_time(input string nm, input int mi, input int s, input int cs);
    chk({nm, "_min"}, int'(bus.min), mi);
    chk({nm, "_sec"}, int'(bus.sec), s);
    chk({nm, "_msec"}, int'(bus.msec), cs);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got=running want=finished");
    errs++;
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    bus.tick_10msec = 1'b0;
    bus.btn_run = 1'b0;
    bus.btn_clear = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b1;
    chk_time("reset", 0, 0, 0);
    chk("reset_running", int'(bus.running), 0);
    chk("reset_rollover", int'(bus.rollover), 0);
    chk("reset_lost", int'(bus.tick_lost), 0);

    // STOP: ticks are ignored, watchdog kept fed
    repeat (5) pulse(11, 29);
    chk_time("stop_ticks", 0, 0, 0);
    chk("stop_lost", int'(bus.tick_lost), 0);

    // RUN: 150 wide pulses -> 00:01.50
    press(1'b1, 1'b0);
    chk("run_on", int'(bus.running), 1);
    pulse(11, 29);
    chk_time("first_tick", 0, 0, 1);
    repeat (149) pulse(11, 29);
    chk_time("t150", 0, 1, 50);
    chk("t150_running", int'(bus.running), 1);

    // Clear is ignored in RUN; run+clear in RUN stops
    press(1'b0, 1'b1);
    chk_time("clr_in_run", 0, 1, 50);
    press(1'b1, 1'b1);
    chk("runclr_stop", int'(bus.running), 0);
    chk_time("runclr_keep", 0, 1, 50);
    // In STOP, run+clear clears and stays stopped
    press(1'b1, 1'b1);
    chk("stopclr_running", int'(bus.running), 0);
    chk_time("stopclr", 0, 0, 0);

    // Preload 59:58.00 instead of 359800 real ticks
    #2;
    force dut.sec_q = 6'd58;
    force dut.min_q = 6'd59;
    #1;
    release dut.sec_q;
    release dut.min_q;
    m_cs = 59 * 6000 + 58 * 100;
    @(negedge clk);
    chk_time("preload", 59, 58, 0);
    press(1'b1, 1'b0);
    repeat (199) pulse(2, 2);
    chk_time("pre_wrap", 59, 59, 99);
    chk("pre_wrap_roll", int'(bus.rollover), 0);
    bus.tick_10msec = 1'b1;
    @(negedge clk);
    chk_time("wrap", 0, 0, 0);
    chk("wrap_roll", int'(bus.rollover), 1);
    bus.tick_10msec = 1'b0;
    @(negedge clk);
    chk("wrap_roll_end", int'(bus.rollover), 0);

    // Watchdog: lost exactly T clocks after the last rise edge
    bus.tick_10msec = 1'b1;
    @(negedge clk);
    bus.tick_10msec = 1'b0;
    repeat (T - 1) @(negedge clk);
    chk("lost_early", int'(bus.tick_lost), 0);
    @(negedge clk);
    chk("lost_set", int'(bus.tick_lost), 1);
    repeat (5) @(negedge clk);
    chk("lost_hold", int'(bus.tick_lost), 1);
    bus.tick_10msec = 1'b1;
    @(negedge clk);
    chk("lost_clear", int'(bus.tick_lost), 0);
    chk_time("lost_count", 0, 0, 2);
    bus.tick_10msec = 1'b0;
    @(negedge clk);

    // Reset while RUN at 00:03.42 with the tick high
    repeat (340) pulse(2, 2);
    chk_time("pre_rst", 0, 3, 42);
    bus.tick_10msec = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_time("mid_rst", 0, 0, 0);
    chk("mid_rst_running", int'(bus.running), 0);
    repeat (3) @(negedge clk);
    press(1'b1, 1'b0);
    chk("rst_run", int'(bus.running), 1);
    repeat (3) @(negedge clk);
    chk_time("held_tick", 0, 0, 0);
    bus.tick_10msec = 1'b0;
    repeat (2) @(negedge clk);
    pulse(2, 2);
    chk_time("after_rst", 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule

// File: doc/tick_stopwatch.md
# tick_stopwatch

Consumer end of the 10 ms tick interface: takes the periodic `tick_10msec` pulse from the tick generator, qualifies it into a single-cycle event by rising-edge detection, and accumulates it into a run/stop/clear stopwatch (centiseconds, seconds, minutes). A watchdog flags loss of the tick stream. Sits between the tick generator and the display/FND formatting logic in the sensor board top level.

## Interface
- `TIMEOUT_CYC`, default 1_100_000: clocks without a tick rising edge before `tick_lost` asserts (10 % margin over the 1_000_000-clock period).
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  reset: one clock; reset is synchronous and active-high.
- `tick_10msec`  in  1  tick from the generator. Multi-cycle high pulse, one per 10 ms. Counted once per rising edge only.
- `btn_run`  in  1  single-cycle, debounced pulse; toggles RUN/STOP.
- `btn_clear`  in  1  single-cycle, debounced pulse; clears time, STOP state only.
- `msec`  out  7  centiseconds, 0–99.
- `sec`  out  6  seconds, 0–59.
- `min`  out  6  minutes, 0–59.
- `running`  out  1  1 while in RUN.
- `rollover`  out  1  one-cycle pulse on wrap 59:59.99 → 00:00.00.
- `tick_lost`  out  1  level; 1 while the tick stream is considered dead.

## Operation
- Edge detect: register `tick_d` samples `tick_10msec` every clock. `tick_rise = tick_10msec & ~tick_d`. `tick_d` resets to 1, so a tick that is already high at reset release is not counted.
- States: STOP (reset state), RUN.
  - STOP + `btn_run` → RUN. RUN + `btn_run` → STOP.
  - STOP + `btn_clear` → msec/sec/min ← 0, stays STOP. In RUN, `btn_clear` is ignored.
  - STOP with `btn_run` and `btn_clear` in the same cycle: clear is applied and `btn_run` is ignored. The state stays STOP.
- Counting applies only in RUN on `tick_rise`. msec increments. At 99 it wraps to 0 and carries into sec. sec 59 wraps to 0 and carries into min. min 59 wraps to 0 and pulses `rollover`.
- A `tick_rise` on the same cycle as a RUN→STOP transition is still counted, because the state is evaluated before the update. A `tick_rise` on the same cycle as STOP→RUN is not counted.
- Watchdog:
  - `gap_cnt`, width clog2(TIMEOUT_CYC+1), clears to 0 on every `tick_rise`. Otherwise it increments and saturates at TIMEOUT_CYC.
  - `tick_lost` = (`gap_cnt` == TIMEOUT_CYC), registered.
  - The watchdog runs in both states.
  - `tick_lost` has no effect on counting. Counting resumes naturally when ticks return.
- Reset mid-operation: all state is discarded on the next clock edge, with no partial increment.

## Timing
- Reset values: msec=0, sec=0, min=0, running=0, rollover=0, tick_lost=0, gap_cnt=0, tick_d=1, state=STOP.
- Latency: if `tick_10msec`=1 and `tick_d`=0 at clock edge k (RUN), the new count is visible immediately after edge k. Exactly one increment per high pulse, regardless of pulse width (1–11+ clocks).
- `running` changes on the edge that samples `btn_run`.
- `rollover` is high for exactly the one cycle following the wrapping edge.
- `tick_lost` rises on the edge where `gap_cnt` reaches TIMEOUT_CYC, i.e. TIMEOUT_CYC clocks after the last `tick_rise` edge. It falls on the edge that registers the next `tick_rise`.
- Buttons are single-cycle; a held button level toggles only once if upstream guarantees single-cycle pulses. This block does not re-edge-detect buttons.

## Test plan
- Reset, then feed `tick_10msec` 11-clock-high pulses every 1_000_000 clocks in STOP → msec/sec/min stay 0 and `tick_lost` stays 0.
- `btn_run` pulse, then 150 ticks (each 11 clocks high) → msec=50, sec=1, min=0, running=1. Each pulse advances by exactly 1.
- Preload via 359_999 fast ticks (bench uses a short period and TIMEOUT_CYC=50) → 59:59.99. One more tick → 00:00.00 and `rollover` high for 1 cycle.
- RUN: `btn_clear` → ignored. Then `btn_run`+`btn_clear` same cycle → stays RUN→STOP. Then in STOP, `btn_run`+`btn_clear` same cycle → count 0, state STOP, running=0.
- TIMEOUT_CYC=50, ticks stop → `tick_lost`=1 exactly 50 clocks after the last rise edge. The next tick → `tick_lost`=0 on that edge, and the count increments if in RUN.
- Assert `rst` for one clock while RUN at 00:03.42 with `tick_10msec` high → all outputs 0, STOP. After release, the still-high tick is not counted.
